// File: rtl/apb_pkg.sv
// apb_pkg: shared APB types and default widths for the master bridge, slave and benches.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: ACCESS wait-state counter; o_hit flags the last permitted wait cycle.
// Only instantiated when APB_MASTER_TIMEOUT_EN is defined.
module apb_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_hit
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Holding at LAST keeps the count from wrapping if the abort is ever delayed.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && !o_hit) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_hit = (r_cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command port to APB3 master (IDLE->SETUP->ACCESS), one response per command.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without pready.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       xfer_cnt,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  apb_state_e        r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [15:0]       r_xfer_cnt;

  logic w_accept;
  logic w_timeout;

  assign cmd_ready = (r_state == IDLE) && !preset;
  assign w_accept  = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic w_ctr_clear;
  logic w_ctr_inc;
  logic w_ctr_hit;

  assign w_ctr_clear = (r_state == SETUP);
  assign w_ctr_inc   = (r_state == ACCESS) && !pready;

  apb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout_ctr (
    .i_clk   (pclk),
    .i_rst   (preset),
    .i_clear (w_ctr_clear),
    .i_inc   (w_ctr_inc),
    .o_hit   (w_ctr_hit)
  );

  // pready on the limit cycle takes priority, so only abort when it is still low.
  assign w_timeout = w_ctr_hit && !pready;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_xfer_cnt  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_paddr  <= cmd_addr;
            r_pwrite <= cmd_write;
            r_pwdata <= cmd_write ? cmd_wdata : '0;
            r_psel   <= 1'b1;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_rsp_err   <= 1'b0;
            r_xfer_cnt  <= r_xfer_cnt + 16'd1;
            r_state     <= IDLE;
          end else if (w_timeout) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign xfer_cnt  = r_xfer_cnt;

endmodule
